fp_writeback_queue: RTL and testbench
=====================================

# fp_writeback_queue

Buffers 64-bit double-precision results from the FP execution units (multiplier, adder) and retires them in order through the single write port of the 16-entry register file. Entries still waiting to be written are forwarded to operand reads, so the register file's two read ports always see the newest value. The block sits directly upstream of the register file's write port and beside its read ports.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- DW, 64, data width (IEEE-754 double)
- AW, 4, register address width

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a result
- in_ready  out  1  queue can accept; push = in_valid & in_ready
- in_data  in  DW  result value
- in_dest  in  AW  destination register
- wb_stall  in  1  register file cannot accept a write this cycle
- wb_we  out  1  write strobe to register file (drives WR and EN)
- wb_addr  out  AW  write address (drives si1)
- wb_data  out  DW  write data (drives I1)
- q_addr1, q_addr2  in  AW  operand addresses being read (mirror so1/so2)
- hit1, hit2  out  1  a pending entry targets q_addrN
- fwd1, fwd2  out  DW  newest pending value for q_addrN
- count  out  $clog2(DEPTH)+1  occupied entries
- full, empty  out  1  count==DEPTH / count==0

## Operation
- Circular buffer of DEPTH entries {valid, dest, data}; write pointer wp, read pointer rp, both $clog2(DEPTH) bits, wrapping modulo DEPTH; count tracks occupancy separately.
- Push: on a clock edge with in_valid & in_ready, store {in_dest, in_data} at wp, set valid, advance wp.
- in_ready = !full & !rst. A push is never accepted while full, even if a pop occurs in the same cycle.
- Head presentation is combinational from the registered head entry: wb_we = !empty & !wb_stall; wb_addr/wb_data = head dest/data when !empty, else 0.
- Pop: on a clock edge with wb_we=1, clear valid at rp and advance rp.
- Push and pop in the same edge: count unchanged, both pointers advance.
- Multiple entries for the same dest are legal and retire in order, so the last write wins in the register file.
- Forwarding: hitN = OR over valid entries with dest==q_addrN. fwdN = data of the youngest such entry (closest to wp-1 going backwards), else 0. A value presented on in_data in the same cycle is not forwarded; it becomes visible the cycle after its push edge. An entry popped at edge N stops hitting after edge N, when the register file holds it.
- No data transformation. Values pass bit-exact, including NaN/Inf payloads.

## Timing
- Reset (async assert, sync use after deassert): wp=rp=0, count=0, all valid=0, empty=1, full=0, in_ready=0 while rst high, wb_we=0, wb_addr=0, wb_data=0, hit1/hit2=0, fwd1/fwd2=0. After rst falls, in_ready=1 in the same cycle.
- Reset mid-operation discards all pending entries with no write-back. The system guarantees the register file is reset at the same time.
- Latency from push edge to wb_we: 1 cycle when the queue was empty and wb_stall=0.
- Throughput: 1 push and 1 pop per cycle sustained.
- wb_stall is sampled combinationally. Holding it high freezes the head with wb_addr/wb_data stable and wb_we=0.
- full asserts the cycle after the DEPTH-th outstanding push and deasserts the cycle after a pop.
- Pointer wrap: after DEPTH pushes, wp returns to 0. Ordering is preserved across the wrap.

## Test plan
- Reset/idle: assert rst mid-stream with 3 entries queued → all outputs 0, empty=1, count=0, no wb_we pulse; after release, in_ready=1.
- Single pass-through: push dest=5, data=64'h4009_21FB_5444_2D18 with wb_stall=0 → next cycle wb_we=1, wb_addr=5, wb_data equal; the following cycle empty=1.
- Fill/stall: wb_stall=1, push 4 entries (dests 1,2,3,4) → full=1, in_ready=0, a 5th push is ignored; release stall → writes retire 1,2,3,4 on consecutive cycles.
- Forwarding priority: wb_stall=1, push {7, 64'h3FF0…0} then {7, 64'h4000…0}, q_addr1=7, q_addr2=8 → hit1=1, fwd1=64'h4000_0000_0000_0000, hit2=0, fwd2=0.
- Wrap and concurrency: a 20-cycle stream of simultaneous push/pop with random wb_stall → write-back sequence exactly matches push order, count never exceeds 4, pointers wrap correctly.
- Same-cycle push on empty queue with q_addr1=in_dest → hit1=0 that cycle, hit1=1 the next cycle, unless the entry was popped at that edge.

Source files
------------

// File: rtl/fp_writeback_queue.sv
// fp_writeback_queue
// In-order write-back buffer between the FP execution units and the single
// register-file write port. Pending entries are forwarded to both operand
// read ports so readers always observe the newest value for a register.
//
// Handshake: a result transfers on a rising edge where in_valid & in_ready
// are both 1; in_valid/in_data/in_dest must be held stable until then.
// On the write side, wb_we is the write strobe and wb_stall is the
// register file's back-pressure; an entry retires on an edge where wb_we=1.
module fp_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 64,
  parameter int AW    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  input  logic [AW-1:0]              in_dest,
  input  logic                       wb_stall,
  output logic                       wb_we,
  output logic [AW-1:0]              wb_addr,
  output logic [DW-1:0]              wb_data,
  input  logic [AW-1:0]              q_addr1,
  input  logic [AW-1:0]              q_addr2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DW-1:0]              fwd1,
  output logic [DW-1:0]              fwd2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [AW-1:0]     dest_q [DEPTH];
  logic [DW-1:0]     data_q [DEPTH];
  logic [PW-1:0]     wp_q;
  logic [PW-1:0]     rp_q;
  logic [CW-1:0]     count_q;

  logic push;
  logic pop;

  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // A pop in the same cycle does not free a slot for a push while full.
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;

  // Head presentation straight from the registered head entry.
  assign wb_we    = !empty && !wb_stall;
  assign wb_addr  = empty ? '0 : dest_q[rp_q];
  assign wb_data  = empty ? '0 : data_q[rp_q];
  assign pop      = wb_we;

  // Walk entries oldest to youngest so the last match (youngest) wins.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
    logic [DW:0]   r;
    logic [PW-1:0] idx;
    r   = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp_q + PW'(k);
      if (valid_q[idx] && (dest_q[idx] == a)) begin
        r = {1'b1, data_q[idx]};
      end
    end
    return r;
  endfunction

  // Operand forwarding for both read ports.
  always_comb begin
    {hit1, fwd1} = lookup(q_addr1);
    {hit2, fwd2} = lookup(q_addr2);
  end

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        valid_q[rp_q] <= 1'b0;
        rp_q          <= rp_q + 1'b1;
      end
      // Push slot differs from pop slot unless empty, where pop is 0.
      if (push) begin
        valid_q[wp_q] <= 1'b1;
        dest_q[wp_q]  <= in_dest;
        data_q[wp_q]  <= in_data;
        wp_q          <= wp_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_writeback_queue.sv
// Directed bench for fp_writeback_queue: reset, pass-through, fill/stall,
// forwarding priority, same-cycle visibility, mid-stream reset and a
// push/pop stream checked against an expected queue.
module tb_fp_writeback_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 64;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_dest;
  logic          wb_stall;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] q_addr1;
  logic [AW-1:0] q_addr2;
  logic          hit1;
  logic          hit2;
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;
  logic [2:0]    count;
  logic          full;
  logic          empty;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [AW+DW-1:0] exp_q[$];

  fp_writeback_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .wb_stall(wb_stall), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .hit1(hit1), .hit2(hit2),
    .fwd1(fwd1), .fwd2(fwd2), .count(count), .full(full), .empty(empty)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = '0;
    in_dest  = '0;
    wb_stall = 1'b0;
    q_addr1  = '0;
    q_addr2  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %0b exp 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0b exp 0", full); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
    n_cmp++; if ({wb_we, wb_addr, wb_data} !== '0) begin n_fail++; $display("FAIL rst_wb got we=%0b a=%0d d=%h exp 0", wb_we, wb_addr, wb_data); end
    n_cmp++; if ({hit1, hit2, fwd1, fwd2} !== '0) begin n_fail++; $display("FAIL rst_fwd got h1=%0b h2=%0b exp 0", hit1, hit2); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %0b exp 1", in_ready); end
    step();
  endtask

  task automatic test_pass_through();
    in_valid = 1'b1; in_dest = 4'd5; in_data = 64'h4009_21FB_5444_2D18;
    step();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL pt_we got %0b exp 1", wb_we); end
    n_cmp++; if (wb_addr !== 4'd5) begin n_fail++; $display("FAIL pt_addr got %0d exp 5", wb_addr); end
    n_cmp++; if (wb_data !== 64'h4009_21FB_5444_2D18) begin n_fail++; $display("FAIL pt_data got %h exp 400921fb54442d18", wb_data); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL pt_count got %0d exp 1", count); end
    step();
    n_cmp++; if (empty !== 1'b1 || wb_we !== 1'b0) begin n_fail++; $display("FAIL pt_empty got e=%0b we=%0b exp e=1 we=0", empty, wb_we); end
  endtask

  task automatic test_fill_stall();
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_dest = AW'(i); in_data = 64'h3FF0_0000_0000_0000 + 64'(i);
      step();
    end
    // Fifth push attempt while full
    in_dest = 4'd9; in_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    n_cmp++; if (full !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got full=%0b rdy=%0b exp 1/0", full, in_ready); end
    n_cmp++; if (wb_we !== 1'b0 || wb_addr !== 4'd1) begin n_fail++; $display("FAIL fill_stall_head got we=%0b a=%0d exp 0/1", wb_we, wb_addr); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_ignored got count=%0d exp 4", count); end
    n_cmp++; if (wb_addr !== 4'd1 || wb_data !== 64'h3FF0_0000_0000_0001) begin n_fail++; $display("FAIL fill_frozen got a=%0d d=%h exp 1/3ff0000000000001", wb_addr, wb_data); end
    wb_stall = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (wb_we !== 1'b1 || wb_addr !== AW'(i) || wb_data !== 64'h3FF0_0000_0000_0000 + 64'(i)) begin
        n_fail++; $display("FAIL drain_%0d got we=%0b a=%0d d=%h exp we=1 a=%0d", i, wb_we, wb_addr, wb_data, i);
      end
      step();
      if (i == 1) begin
        n_cmp++; if (full !== 1'b0 || count !== 3'd3) begin n_fail++; $display("FAIL drain_unfull got full=%0b count=%0d exp 0/3", full, count); end
      end
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %0b exp 1", empty); end
  endtask

  task automatic test_forward_priority();
    wb_stall = 1'b1;
    in_valid = 1'b1; in_dest = 4'd7; in_data = 64'h3FF0_0000_0000_0000;
    step();
    in_data = 64'h4000_0000_0000_0000;
    step();
    in_valid = 1'b0; q_addr1 = 4'd7; q_addr2 = 4'd8;
    #1;
    n_cmp++; if (hit1 !== 1'b1 || fwd1 !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL fwd_young got h=%0b d=%h exp 1/4000000000000000", hit1, fwd1); end
    n_cmp++; if (hit2 !== 1'b0 || fwd2 !== 64'h0) begin n_fail++; $display("FAIL fwd_miss got h=%0b d=%h exp 0/0", hit2, fwd2); end
    wb_stall = 1'b0;
    step();
    n_cmp++; if (hit1 !== 1'b1 || fwd1 !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL fwd_after_pop got h=%0b d=%h exp 1/4000000000000000", hit1, fwd1); end
    step();
    n_cmp++; if (hit1 !== 1'b0 || fwd1 !== 64'h0) begin n_fail++; $display("FAIL fwd_retired got h=%0b d=%h exp 0/0", hit1, fwd1); end
    q_addr1 = '0; q_addr2 = '0;
  endtask

  task automatic test_same_cycle();
    wb_stall = 1'b0;
    in_valid = 1'b1; in_dest = 4'd3; in_data = 64'h7FF8_0000_DEAD_BEEF; q_addr1 = 4'd3;
    #1;
    n_cmp++; if (hit1 !== 1'b0) begin n_fail++; $display("FAIL same_cycle_hit got %0b exp 0", hit1); end
    step();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (hit1 !== 1'b1 || fwd1 !== 64'h7FF8_0000_DEAD_BEEF) begin n_fail++; $display("FAIL next_cycle_hit got h=%0b d=%h exp 1/7ff80000deadbeef", hit1, fwd1); end
    step();
    n_cmp++; if (hit1 !== 1'b0) begin n_fail++; $display("FAIL popped_hit got %0b exp 0", hit1); end
    q_addr1 = '0;
  endtask

  task automatic test_reset_mid();
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_dest = AW'(10 + i); in_data = 64'hFFF0_0000_0000_0000;
      step();
    end
    in_valid = 1'b0; q_addr1 = 4'd10; wb_stall = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_count got c=%0d e=%0b exp 0/1", count, empty); end
    n_cmp++; if ({wb_we, wb_addr, wb_data, hit1, fwd1, in_ready} !== '0) begin n_fail++; $display("FAIL mid_rst_outs got we=%0b h1=%0b rdy=%0b exp 0", wb_we, hit1, in_ready); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || wb_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_release got rdy=%0b we=%0b exp 1/0", in_ready, wb_we); end
    q_addr1 = '0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [AW+DW-1:0] head;
    logic             exp_we;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      in_valid = (i < 20);
      in_dest  = AW'(i);
      in_data  = 64'h7FF8_0000_0000_0000 | 64'(i * 17 + 1);
      wb_stall = (i < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      exp_we = (exp_q.size() != 0) && !wb_stall;
      n_cmp++; if (count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL b2b_count cyc %0d got %0d exp %0d", i, count, exp_q.size()); end
      n_cmp++; if (in_ready !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL b2b_ready cyc %0d got %0b exp %0b", i, in_ready, exp_q.size() < DEPTH); end
      n_cmp++; if (wb_we !== exp_we) begin n_fail++; $display("FAIL b2b_we cyc %0d got %0b exp %0b", i, wb_we, exp_we); end
      if (exp_we) begin
        head = exp_q.pop_front();
        n_cmp++; if ({wb_addr, wb_data} !== head) begin n_fail++; $display("FAIL b2b_order cyc %0d got a=%0d d=%h exp a=%0d d=%h", i, wb_addr, wb_data, head[AW+DW-1:DW], head[DW-1:0]); end
      end
      if (in_valid && (exp_q.size() + (exp_we ? 1 : 0)) < DEPTH) exp_q.push_back({in_dest, in_data});
      step();
    end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (exp_q.size() != 0 || empty !== 1'b1) begin n_fail++; $display("FAIL b2b_drained got left=%0d empty=%0b exp 0/1", exp_q.size(), empty); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill_stall();
    test_forward_priority();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
